// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrate, execute, respond.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 over req1); default is round-robin.
module alu_arbiter #(
    parameter int size = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic            req1,
    input  logic [3:0]      op0,
    input  logic [3:0]      op1,
    input  logic [size-1:0] a0,
    input  logic [size-1:0] b0,
    input  logic [size-1:0] a1,
    input  logic [size-1:0] b1,
    output logic            gnt0,
    output logic            gnt1,
    output logic [3:0]      alu_sel,
    output logic [size-1:0] alu_a,
    output logic [size-1:0] alu_b,
    input  logic [size-1:0] alu_result,
    output logic            done0,
    output logic            done1,
    output logic [size-1:0] result,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            winner;
    logic            illegal_q;
    logic [3:0]      op_q;
    logic [size-1:0] a_q;
    logic [size-1:0] b_q;
    logic [size-1:0] result_q;

    logic            pick;
    logic [3:0]      pick_op;
    logic [size-1:0] pick_a;
    logic [size-1:0] pick_b;
    logic            pick_illegal;
    logic            any_req;

    assign any_req = req0 | req1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // req0 beats req1 whenever both are present
    always_comb begin
        pick = !req0;
    end
`else
    logic last;

    // On contention, hand the slot to whoever was not served last
    always_comb begin
        pick = !req0;
        if (req0 && req1) begin
            pick = !last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (state == RESP) begin
            last <= winner;
        end
    end
`endif

    always_comb begin
        pick_op      = pick ? op1 : op0;
        pick_a       = pick ? a1 : a0;
        pick_b       = pick ? b1 : b0;
        pick_illegal = pick_op > 4'b1000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Illegal selects are squashed to 0 at latch time so EXEC just replays the register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner    <= 1'b0;
            illegal_q <= 1'b0;
            op_q      <= 4'b0000;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                winner    <= pick;
                illegal_q <= pick_illegal;
                op_q      <= pick_illegal ? 4'b0000 : pick_op;
                a_q       <= pick_a;
                b_q       <= pick_b;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
            end
        end
    end

    always_comb begin
        gnt0    = (state == EXEC) && !winner;
        gnt1    = (state == EXEC) && winner;
        alu_sel = (state == EXEC) ? op_q : 4'b0000;
        alu_a   = (state == EXEC) ? a_q : '0;
        alu_b   = (state == EXEC) ? b_q : '0;
        done0   = (state == RESP) && !winner;
        done1   = (state == RESP) && winner;
        err     = (state == RESP) && illegal_q;
        result  = result_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int size = 4;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            req0  = 1'b0;
    logic            req1  = 1'b0;
    logic [3:0]      op0   = 4'd0;
    logic [3:0]      op1   = 4'd0;
    logic [size-1:0] a0    = '0;
    logic [size-1:0] b0    = '0;
    logic [size-1:0] a1    = '0;
    logic [size-1:0] b1    = '0;
    logic            gnt0;
    logic            gnt1;
    logic [3:0]      alu_sel;
    logic [size-1:0] alu_a;
    logic [size-1:0] alu_b;
    logic [size-1:0] alu_result;
    logic            done0;
    logic            done1;
    logic [size-1:0] result;
    logic            err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.size(size)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .op0        (op0),
        .op1        (op1),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .done0      (done0),
        .done1      (done1),
        .result     (result),
        .err        (err)
    );

    // Stand-in for the external ALU result mux
    function automatic logic [size-1:0] alu_fn(input logic [3:0] sel, input logic [size-1:0] a,
                                               input logic [size-1:0] b);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return a << 1;
            4'd7:    return a >> 1;
            4'd8:    return b;
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_sel, alu_a, alu_b);

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction model: one operation in flight, stage 0 free, 1 granted, 2 responding
    int              m_stage = 0;
    logic            m_who   = 1'b0;
    logic            m_last  = 1'b1;
    logic [3:0]      m_op    = 4'd0;
    logic [size-1:0] m_a     = '0;
    logic [size-1:0] m_b     = '0;
    logic [size-1:0] m_result = '0;

    function automatic logic choose(input logic r0, input logic r1, input logic last_served);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return r0 ? 1'b0 : 1'b1;
`else
        if (r0 && r1) return (last_served == 1'b0) ? 1'b1 : 1'b0;
        return r0 ? 1'b0 : 1'b1;
`endif
    endfunction

    function automatic logic [3:0] eff_op(input logic [3:0] op);
        return (op > 4'd8) ? 4'd0 : op;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stage  <= 0;
            m_last   <= 1'b1;
            m_result <= '0;
        end else if (m_stage == 0) begin
            if (req0 || req1) begin
                m_who   <= choose(req0, req1, m_last);
                m_op    <= choose(req0, req1, m_last) ? op1 : op0;
                m_a     <= choose(req0, req1, m_last) ? a1 : a0;
                m_b     <= choose(req0, req1, m_last) ? b1 : b0;
                m_stage <= 1;
            end
        end else if (m_stage == 1) begin
            m_result <= alu_fn(eff_op(m_op), m_a, m_b);
            m_stage  <= 2;
        end else begin
            m_last  <= m_who;
            m_stage <= 0;
        end
    end

    always @(negedge clk) begin
        check_output("gnt0",    32'(gnt0),    32'(m_stage == 1 && !m_who));
        check_output("gnt1",    32'(gnt1),    32'(m_stage == 1 && m_who));
        check_output("alu_sel", 32'(alu_sel), 32'((m_stage == 1) ? eff_op(m_op) : 4'd0));
        check_output("alu_a",   32'(alu_a),   32'((m_stage == 1) ? m_a : '0));
        check_output("alu_b",   32'(alu_b),   32'((m_stage == 1) ? m_b : '0));
        check_output("done0",   32'(done0),   32'(m_stage == 2 && !m_who));
        check_output("done1",   32'(done1),   32'(m_stage == 2 && m_who));
        check_output("err",     32'(err),     32'(m_stage == 2 && m_op > 4'd8));
        check_output("result",  32'(result),  32'(m_result));
        check_output("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
    end

    task automatic apply_stimulus(input logic r0, input logic r1, input logic [3:0] o0, input logic [3:0] o1,
                                  input logic [size-1:0] x0, input logic [size-1:0] y0,
                                  input logic [size-1:0] x1, input logic [size-1:0] y1);
        req0 = r0;
        req1 = r1;
        op0  = o0;
        op1  = o1;
        a0   = x0;
        b0   = y0;
        a1   = x1;
        b1   = y1;
    endtask

    logic g0 [0:7];
    logic g1 [0:7];

    initial begin
        // Reset values while rst_n is held low
        @(negedge clk);
        check_output("rst_gnt0", 32'(gnt0), 32'd0);
        check_output("rst_sel", 32'(alu_sel), 32'd0);
        check_output("rst_result", 32'(result), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        repeat (10) begin
            @(negedge clk);
            check_output("idle_ctl", 32'({gnt0, gnt1, done0, done1, err}), 32'd0);
            check_output("idle_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
        end
        @(posedge clk); #1;

        // Single request: op 2 is AND, 5 & 3 = 1
        apply_stimulus(1'b1, 1'b0, 4'd2, 4'd0, 4'd5, 4'd3, 4'd0, 4'd0);
        @(posedge clk); @(negedge clk);
        check_output("single_gnt0", 32'(gnt0), 32'd1);
        check_output("single_sel", 32'(alu_sel), 32'd2);
        check_output("single_a", 32'(alu_a), 32'd5);
        check_output("single_b", 32'(alu_b), 32'd3);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        check_output("single_done0", 32'(done0), 32'd1);
        check_output("single_result", 32'(result), 32'd1);
        @(posedge clk); #1;

        // Contention straight after reset
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b1, 4'd0, 4'd1, 4'd1, 4'd2, 4'd9, 4'd4);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            g0[k] = gnt0;
            g1[k] = gnt1;
        end
        check_output("slot1_gnt0", 32'(g0[1]), 32'd1);
        check_output("slot1_gnt1", 32'(g1[1]), 32'd0);
`ifdef ALU_ARB_FIXED_PRIO_EN
        check_output("slot2_gnt0", 32'(g0[4]), 32'd1);
`else
        check_output("slot2_gnt1", 32'(g1[4]), 32'd1);
`endif
        check_output("slot3_gnt0", 32'(g0[7]), 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Illegal op runs as select 0 (add): 6 + 2 = 8
        apply_stimulus(1'b0, 1'b1, 4'd0, 4'd15, 4'd0, 4'd0, 4'd6, 4'd2);
        @(posedge clk); @(negedge clk);
        check_output("illegal_gnt1", 32'(gnt1), 32'd1);
        check_output("illegal_sel", 32'(alu_sel), 32'd0);
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        check_output("illegal_done1", 32'(done1), 32'd1);
        check_output("illegal_err", 32'(err), 32'd1);
        check_output("illegal_result", 32'(result), 32'd8);
        @(posedge clk); #1;

        // Operands changed after the sampling edge must not leak in: 7 + 1 = 8
        apply_stimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd7, 4'd1, 4'd0, 4'd0);
        @(posedge clk); #1;
        a0 = 4'd9;
        @(negedge clk);
        check_output("hold_a", 32'(alu_a), 32'd7);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        check_output("hold_result", 32'(result), 32'd8);
        @(posedge clk); #1;

        // Reset during EXEC aborts the operation
        apply_stimulus(1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd5, 4'd2);
        @(posedge clk); #1;
        check_output("abort_gnt1", 32'(gnt1), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("abort_ctl", 32'({gnt0, gnt1, done0, done1, err}), 32'd0);
        check_output("abort_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
        check_output("abort_result", 32'(result), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b1, 4'd4, 4'd1, 4'd3, 4'd5, 4'd5, 4'd2);
        @(negedge clk);
        check_output("abort_no_done1", 32'(done1), 32'd0);
        @(negedge clk);
        check_output("after_abort_gnt0", 32'(gnt0), 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check_output("after_abort_done0", 32'(done0), 32'd1);
        check_output("after_abort_result", 32'(result), 32'd6);
        @(posedge clk); #1;

        // Random traffic; requesters hold req until they see their grant
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
            if (gnt0 || !req0) begin
                req0 = ($urandom_range(0, 2) == 0);
                op0  = 4'($urandom_range(0, 15));
                a0   = size'($urandom);
                b0   = size'($urandom);
            end
            if (gnt1 || !req1) begin
                req1 = ($urandom_range(0, 2) == 0);
                op1  = 4'($urandom_range(0, 15));
                a1   = size'($urandom);
                b1   = size'($urandom);
            end
        end

        req0  = 1'b0;
        req1  = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: size, 4, operand/result width in bits, matching the ALU result mux.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: req0 / req1  input  1 each  requester 0 / 1 asks for one ALU operation; held high until its gnt is seen.
REQ-005 Port: op0 / op1  input  4 each  requested ALU select code, valid while the matching req is high.
REQ-006 Port: a0, b0 / a1, b1  input  size each  requester operands, valid while the matching req is high.
REQ-007 Port: gnt0 / gnt1  output  1 each  one-cycle grant pulse; operands have been latched.
REQ-008 Port: alu_sel  output  4  select code driven to the ALU result mux.
REQ-009 Port: alu_a / alu_b  output  size each  operands driven to the ALU.
REQ-010 Port: alu_result  input  size  combinational ALU mux output for the current alu_sel/alu_a/alu_b.
REQ-011 Port: done0 / done1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-012 Port: result  output  size  registered result, valid while either done is high.
REQ-013 Port: err  output  1  one-cycle pulse alongside done when the granted op was illegal (op > 4'b1000).

Function
REQ-014 FSM states: IDLE, EXEC, RESP; transitions only on the rising edge of clk.
REQ-015 IDLE: if no req is high, stay in IDLE; otherwise select a winner, latch its op/a/b, and go to EXEC.
REQ-016 Arbitration (default): round-robin on a 1-bit last pointer; on contention, grant the requester not granted last; a single requester always wins.
REQ-017 EXEC lasts exactly one cycle: gnt of the winner high; alu_sel/alu_a/alu_b driven from the latched registers; at the closing edge, capture alu_result into result and go to RESP.
REQ-018 RESP lasts exactly one cycle: done of the winner high, result stable, err high if applicable; last pointer updated to the winner at the closing edge; next state IDLE.
REQ-019 Latency: from the edge sampling req in IDLE, gnt is high 0 cycles later (the EXEC cycle) and done is high 1 cycle later; peak throughput is one operation per 3 cycles.
REQ-020 Illegal op (op > 4'b1000): the latched op is replaced by 4'b0000 on alu_sel, result = alu_result for select 0, and err pulses in RESP.
REQ-021 Outside EXEC: alu_sel = 4'b0000, alu_a = 0, alu_b = 0.
REQ-022 Outside RESP: done0/done1/err are 0; result holds its last captured value.
REQ-023 req, op or operand changes after the sampling edge do not affect the operation in flight.
REQ-024 A req still high in RESP is re-arbitrated in the following IDLE cycle; it is not granted twice without passing through IDLE.
REQ-025 gnt0 and gnt1 are never high together; done0 and done1 are never high together.

Reset
REQ-026 rst_n low asynchronously forces: state IDLE, gnt0 = gnt1 = done0 = done1 = err = 0, alu_sel = 0, alu_a = alu_b = 0, result = 0, last = 1 (requester 0 wins the first contention).
REQ-027 Reset asserted in EXEC or RESP aborts the operation; no done is issued for it after rst_n releases.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority (req0 always beats req1) and the last pointer is not used.
REQ-029 When ALU_ARB_FIXED_PRIO_EN is undefined, the REQ-016 round-robin behaviour applies.
REQ-030 All other behaviour is identical with and without ALU_ARB_FIXED_PRIO_EN.

Verification
REQ-031 Single request: req0=1, op0=4'b0010, a0=5, b0=3 with a model ALU -> gnt0 pulses the next cycle with alu_sel=2, alu_a=5, alu_b=3; done0 pulses one cycle later with result = model output.
REQ-032 Contention after reset: req0 = req1 = 1 held high -> grants go gnt0, gnt1, gnt0 on successive 3-cycle slots (round-robin); with ALU_ARB_FIXED_PRIO_EN, gnt0 every slot and req1 starves.
REQ-033 Illegal op: req1=1, op1=4'b1111 -> alu_sel=0 during EXEC; done1 and err both high in RESP.
REQ-034 Operand change: a0 changed from 7 to 9 during EXEC -> alu_a stays 7 and result reflects 7.
REQ-035 Reset mid-operation: rst_n pulsed low during EXEC -> all outputs 0 immediately; no done1/done0 for the aborted op; first contention after release grants req0.
REQ-036 Idle: no req for 10 cycles -> state stays IDLE; alu_sel, alu_a, alu_b, gnt, done and err all 0.
